ssf_out_collector: RTL and testbench
====================================

Name: ssf_out_collector

Overview:
- Downstream stage of the 31-instance SSF bank. Consumes the bank's arbitrated output bus (32-bit signed sample plus 2-bit output-enable code).
- Captures every valid sample with a sequence tag into a FIFO and drains it to the readout/host side over a valid/ready stream.
- Reports fill level and overflow so software can detect dropped filter outputs.

Parameters:
- DATA_W, 32, sample width; must equal the SSF bank output width.
- DEPTH, 64, FIFO depth in entries; power of two, minimum 4.
- TAG_W, 16, sequence-tag width.
- OVF_W, 16, overflow counter width.

Ports:
- clk  in  1  single system clock, all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- in_data  in  DATA_W  signed sample from the SSF bank output mux.
- in_en  in  2  bank output-enable code; 2'd1 = sample valid, all other codes = no sample.
- clear  in  1  synchronous flush of FIFO and counters.
- m_data  out  DATA_W  head-of-FIFO sample.
- m_tag  out  TAG_W  sequence tag of the head sample.
- m_valid  out  1  head entry present.
- m_ready  in  1  consumer accepts head this cycle.
- level  out  $clog2(DEPTH)+1  current occupancy.
- ovf  out  1  sticky: at least one sample dropped since reset/clear.
- ovf_cnt  out  OVF_W  dropped-sample count, saturating.
- bad_en  out  1  sticky: in_en seen at 2'd2 or 2'd3.

Behaviour:
- Reset (async assert, sync release): FIFO empty, m_valid=0, m_data=0, m_tag=0, level=0, ovf=0, ovf_cnt=0, bad_en=0, seq counter=0.
- push = (in_en==2'd1); pop = m_valid && m_ready.
- Sequence counter seq:
  - Increments on every push, accepted or dropped.
  - Wraps modulo 2^TAG_W.
  - Each accepted entry stores {in_data, seq value before the increment}, so the consumer sees tag gaps on drops.
- Write rule, evaluated at the edge:
  - Accepted if level<DEPTH, or if level==DEPTH and pop is asserted in the same cycle (simultaneous push+pop when full).
  - Otherwise the sample is dropped: ovf<=1 and ovf_cnt increments, holding at all-ones.
- First-word fall-through: a sample pushed into an empty FIFO at edge N gives m_valid=1 and m_data/m_tag valid after edge N. Latency is one cycle.
- m_data and m_tag remain stable while m_valid=1 and m_ready=0.
- Pop on an empty FIFO cannot occur, since m_valid=0; m_ready is ignored.
- level update: +1 on accepted push only, -1 on pop only, unchanged on push+pop.
- Read/write pointers use $clog2(DEPTH) bits and wrap naturally.
- in_en==2'd2 or 2'd3 sets bad_en. No data is written and seq does not increment.
- clear=1 at an edge:
  - Empties the FIFO and zeroes seq, ovf, ovf_cnt and bad_en.
  - Overrides any push or pop in the same cycle; that sample is discarded and not counted.
  - m_valid=0 after the edge.
- Reset asserted mid-stream: outputs go to reset values immediately (asynchronous); no partial entry survives.

Decomposition:
- Package ssf_pkg holds:
  - SSF_DATA_W=32.
  - Output-enable code constants: SSF_EN_IDLE=2'd0, SSF_EN_VALID=2'd1.
  - Request code SSF_REQ_ON=2'd1.
  - These are shared with the SSF bank and its mux.
- One sub-module, ssf_sync_fifo: parameterised width/depth FIFO with FWFT output, push/pop/clear, level, full/empty.
- The top level adds tagging, the drop policy, the sticky flags and the counters.

Test Plan:
- Push 3 samples (in_en=1; data -5, 7, 100) with m_ready=0 -> level=3, m_valid=1, m_data=-5, m_tag=0. Then m_ready=1 for 3 cycles -> outputs -5/0, 7/1, 100/2, then m_valid=0, level=0.
- DEPTH=4, m_ready=0, 6 consecutive pushes (data 1..6) -> level=4, ovf=1, ovf_cnt=2. Drain yields tags 0,1,2,3 with data 1..4.
- Full FIFO, push data 9 with m_ready=1 in the same cycle -> accepted, level stays 4, ovf_cnt unchanged, last drained entry data 9.
- in_en=2'd2 for 1 cycle, then in_en=2'd1 with data 42 -> bad_en=1, level=1, m_tag=0 (no seq advance on the bad code).
- Seq wrap with TAG_W=4: 17 pushes with continuous draining -> tags 0..15 then 0.
- clear with push asserted in the same cycle and level=2 -> level=0, m_valid=0, ovf_cnt=0, ovf=0; next push gets tag 0.
- Assert rst mid-drain with level=3 -> m_valid drops before the next clock edge; after release, level=0 and ovf_cnt=0.

Source files
------------

// File: rtl/ssf_pkg.sv
// Constants shared by the SSF bank, its output mux and the output collector.
package ssf_pkg;

    localparam int SSF_DATA_W = 32;

    localparam logic [1:0] SSF_EN_IDLE  = 2'd0;
    localparam logic [1:0] SSF_EN_VALID = 2'd1;
    localparam logic [1:0] SSF_REQ_ON   = 2'd1;

    // Codes 2 and 3 are never driven by a healthy bank.
    function automatic logic ssf_en_illegal(input logic [1:0] en);
        return en[1];
    endfunction

endpackage

// File: rtl/ssf_out_collector_if.sv
// Bank-side sample bus plus the readout valid/ready stream of the output collector.
interface ssf_out_collector_if
    import ssf_pkg::*;
#(
    parameter int DATA_W = SSF_DATA_W,
    parameter int TAG_W  = 16
);
    logic [DATA_W-1:0] in_data;
    logic [1:0]        in_en;
    logic [DATA_W-1:0] m_data;
    logic [TAG_W-1:0]  m_tag;
    logic              m_valid;
    logic              m_ready;

    modport master (
        input  in_data, in_en, m_ready,
        output m_data, m_tag, m_valid
    );

    modport slave (
        output in_data, in_en, m_ready,
        input  m_data, m_tag, m_valid
    );
endinterface

// File: rtl/ssf_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; a push into a full FIFO is taken
// only when the head is popped on the same edge.
module ssf_sync_fifo #(
    parameter  int WIDTH = 48,
    parameter  int DEPTH = 64,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [LVL_W-1:0] level,
    output logic             full,
    output logic             empty
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             do_push, do_pop;

    assign empty   = (level_q == '0);
    assign full    = (level_q == LVL_W'(DEPTH));
    assign do_pop  = pop && !empty && !clear;
    assign do_push = push && (!full || do_pop) && !clear;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (do_push && !do_pop)      level_d = level_q + 1'b1;
            else if (do_pop && !do_push) level_d = level_q - 1'b1;
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // NOTE: storage has no reset; stale words are never visible because rdata is masked while empty.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = empty ? '0 : mem_q[rd_ptr_q];
    assign level = level_q;

endmodule

// File: rtl/ssf_out_collector.sv
// Tags each valid SSF bank sample, buffers it for the readout stream and
// tracks drops and illegal enable codes.
module ssf_out_collector
    import ssf_pkg::*;
#(
    parameter  int DATA_W = SSF_DATA_W,
    parameter  int DEPTH  = 64,
    parameter  int TAG_W  = 16,
    parameter  int OVF_W  = 16,
    localparam int LVL_W  = $clog2(DEPTH) + 1
) (
    input  logic                clk,
    input  logic                rst,
    ssf_out_collector_if.master bus,
    input  logic                clear,
    output logic [LVL_W-1:0]    level,
    output logic                ovf,
    output logic [OVF_W-1:0]    ovf_cnt,
    output logic                bad_en
);
    logic             push, pop, accept, full, empty;
    logic [TAG_W-1:0] seq_q, seq_d;
    logic             ovf_q, ovf_d;
    logic [OVF_W-1:0] ovf_cnt_q, ovf_cnt_d;
    logic             bad_en_q, bad_en_d;

    assign push   = (bus.in_en == SSF_EN_VALID);
    assign pop    = bus.m_valid && bus.m_ready;
    assign accept = push && (!full || pop);

    ssf_sync_fifo #(
        .WIDTH (DATA_W + TAG_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .push  (push),
        .pop   (pop),
        .wdata ({bus.in_data, seq_q}),
        .rdata ({bus.m_data, bus.m_tag}),
        .level (level),
        .full  (full),
        .empty (empty)
    );

    // The tag advances on dropped samples too, so drops show up as tag gaps downstream.
    always_comb begin
        seq_d     = seq_q;
        ovf_d     = ovf_q;
        ovf_cnt_d = ovf_cnt_q;
        bad_en_d  = bad_en_q;
        if (clear) begin
            seq_d     = '0;
            ovf_d     = 1'b0;
            ovf_cnt_d = '0;
            bad_en_d  = 1'b0;
        end else begin
            if (push) seq_d = seq_q + 1'b1;
            if (push && !accept) begin
                ovf_d = 1'b1;
                if (ovf_cnt_q != '1) ovf_cnt_d = ovf_cnt_q + 1'b1;
            end
            if (ssf_en_illegal(bus.in_en)) bad_en_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seq_q     <= '0;
            ovf_q     <= 1'b0;
            ovf_cnt_q <= '0;
            bad_en_q  <= 1'b0;
        end else begin
            seq_q     <= seq_d;
            ovf_q     <= ovf_d;
            ovf_cnt_q <= ovf_cnt_d;
            bad_en_q  <= bad_en_d;
        end
    end

    assign bus.m_valid = !empty;
    assign ovf         = ovf_q;
    assign ovf_cnt     = ovf_cnt_q;
    assign bad_en      = bad_en_q;

endmodule

// File: tb/tb_ssf_out_collector.sv
// Bench for ssf_out_collector: directed vector table, corner sequences and
// random traffic against a queue-based reference model.
module tb_ssf_out_collector;
    import ssf_pkg::*;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int TW    = 4;
    localparam int OW    = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          clear = 1'b0;
    logic [LW-1:0] level;
    logic          ovf;
    logic [OW-1:0] ovf_cnt;
    logic          bad_en;

    ssf_out_collector_if #(.DATA_W(DW), .TAG_W(TW)) bus ();

    ssf_out_collector #(
        .DATA_W (DW),
        .DEPTH  (DEPTH),
        .TAG_W  (TW),
        .OVF_W  (OW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .clear   (clear),
        .level   (level),
        .ovf     (ovf),
        .ovf_cnt (ovf_cnt),
        .bad_en  (bad_en)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a bounded queue of {data, tag} plus plain counters.
    typedef struct {
        logic [DW-1:0] d;
        logic [TW-1:0] t;
    } ent_t;

    ent_t mq[$];
    int   m_seq;
    bit   m_ovf;
    bit   m_bad;
    int   m_cnt;

    function automatic void model_reset();
        mq.delete();
        m_seq = 0;
        m_ovf = 0;
        m_bad = 0;
        m_cnt = 0;
    endfunction

    function automatic void model_edge();
        ent_t e;
        if (clear) begin
            model_reset();
            return;
        end
        if (bus.in_en >= 2'd2) m_bad = 1;
        if (mq.size() > 0 && bus.m_ready) void'(mq.pop_front());
        if (bus.in_en == 2'd1) begin
            if (mq.size() < DEPTH) begin
                e.d = bus.in_data;
                e.t = TW'(m_seq);
                mq.push_back(e);
            end else begin
                m_ovf = 1;
                if (m_cnt < (2**OW) - 1) m_cnt++;
            end
            m_seq = (m_seq + 1) % (2**TW);
        end
    endfunction

    task automatic compare_model(input string where);
        check({where, ".level"},   64'(level),       64'(mq.size()));
        check({where, ".m_valid"}, 64'(bus.m_valid), 64'(mq.size() > 0));
        check({where, ".ovf"},     64'(ovf),         64'(m_ovf));
        check({where, ".ovf_cnt"}, 64'(ovf_cnt),     64'(m_cnt));
        check({where, ".bad_en"},  64'(bad_en),      64'(m_bad));
        if (mq.size() > 0) begin
            check({where, ".m_data"}, 64'(bus.m_data), 64'(mq[0].d));
            check({where, ".m_tag"},  64'(bus.m_tag),  64'(mq[0].t));
        end
    endtask

    task automatic drive(input logic [1:0] en, input logic [DW-1:0] d, input logic rdy, input logic clr);
        bus.in_en   = en;
        bus.in_data = d;
        bus.m_ready = rdy;
        clear       = clr;
    endtask

    task automatic tick(input string where);
        model_edge();
        @(posedge clk);
        #1;
        compare_model(where);
    endtask

    typedef struct {
        logic [1:0]    en;
        logic [DW-1:0] d;
        logic          rdy;
        logic          clr;
        int            lvl;
        logic          vld;
        logic [DW-1:0] ed;
        logic [TW-1:0] et;
        logic          bad;
    } vec_t;

    vec_t vt[10];
    logic [DW-1:0] last_d;
    logic [TW-1:0] last_t;

    initial begin
        vt[0] = '{2'd1, -32'sd5, 1'b0, 1'b0, 1, 1'b1, -32'sd5, 4'd0, 1'b0};
        vt[1] = '{2'd1, 32'd7,   1'b0, 1'b0, 2, 1'b1, -32'sd5, 4'd0, 1'b0};
        vt[2] = '{2'd1, 32'd100, 1'b0, 1'b0, 3, 1'b1, -32'sd5, 4'd0, 1'b0};
        vt[3] = '{2'd0, 32'd0,   1'b1, 1'b0, 2, 1'b1, 32'd7,   4'd1, 1'b0};
        vt[4] = '{2'd0, 32'd0,   1'b1, 1'b0, 1, 1'b1, 32'd100, 4'd2, 1'b0};
        vt[5] = '{2'd0, 32'd0,   1'b1, 1'b0, 0, 1'b0, 32'd0,   4'd0, 1'b0};
        vt[6] = '{2'd0, 32'd0,   1'b0, 1'b1, 0, 1'b0, 32'd0,   4'd0, 1'b0};
        vt[7] = '{2'd2, 32'd0,   1'b0, 1'b0, 0, 1'b0, 32'd0,   4'd0, 1'b1};
        vt[8] = '{2'd1, 32'd42,  1'b0, 1'b0, 1, 1'b1, 32'd42,  4'd0, 1'b1};
        vt[9] = '{2'd0, 32'd0,   1'b1, 1'b0, 0, 1'b0, 32'd0,   4'd0, 1'b1};

        drive(SSF_EN_IDLE, '0, 1'b0, 1'b0);
        model_reset();
        #1 rst = 1'b1;
        #1;
        check("reset.level",   64'(level),       64'd0);
        check("reset.m_valid", 64'(bus.m_valid), 64'd0);
        check("reset.m_data",  64'(bus.m_data),  64'd0);
        check("reset.m_tag",   64'(bus.m_tag),   64'd0);
        check("reset.ovf",     64'(ovf),         64'd0);
        check("reset.ovf_cnt", 64'(ovf_cnt),     64'd0);
        check("reset.bad_en",  64'(bad_en),      64'd0);
        #2 rst = 1'b0;

        // Directed table: basic FWFT drain, clear, illegal code without seq advance.
        for (int i = 0; i < 10; i++) begin
            drive(vt[i].en, vt[i].d, vt[i].rdy, vt[i].clr);
            tick($sformatf("vec%0d", i));
            check($sformatf("vec%0d.level", i),   64'(level),       64'(vt[i].lvl));
            check($sformatf("vec%0d.m_valid", i), 64'(bus.m_valid), 64'(vt[i].vld));
            check($sformatf("vec%0d.bad_en", i),  64'(bad_en),      64'(vt[i].bad));
            if (vt[i].vld) begin
                check($sformatf("vec%0d.m_data", i), 64'(bus.m_data), 64'(vt[i].ed));
                check($sformatf("vec%0d.m_tag", i),  64'(bus.m_tag),  64'(vt[i].et));
            end
        end

        // Six pushes into a 4-deep FIFO: two drops, drain returns the first four.
        drive(SSF_EN_IDLE, '0, 1'b0, 1'b1);
        tick("ovf.clear");
        for (int i = 1; i <= 6; i++) begin
            drive(SSF_EN_VALID, DW'(i), 1'b0, 1'b0);
            tick("ovf.push");
        end
        check("ovf.level",   64'(level),   64'd4);
        check("ovf.flag",    64'(ovf),     64'd1);
        check("ovf.cnt",     64'(ovf_cnt), 64'd2);
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("ovf.drain%0d.data", i), 64'(bus.m_data), 64'(i));
            check($sformatf("ovf.drain%0d.tag", i),  64'(bus.m_tag),  64'(i - 1));
            drive(SSF_EN_IDLE, '0, 1'b1, 1'b0);
            tick("ovf.drain");
        end
        check("ovf.empty", 64'(bus.m_valid), 64'd0);

        // Push while full with the head popped on the same edge.
        drive(SSF_EN_IDLE, '0, 1'b0, 1'b1);
        tick("pp.clear");
        for (int i = 0; i < 4; i++) begin
            drive(SSF_EN_VALID, DW'(10 + i), 1'b0, 1'b0);
            tick("pp.fill");
        end
        drive(SSF_EN_VALID, 32'd9, 1'b1, 1'b0);
        tick("pp.pushpop");
        check("pp.level", 64'(level),   64'd4);
        check("pp.cnt",   64'(ovf_cnt), 64'd0);
        last_d = '0;
        last_t = '0;
        for (int i = 0; i < 4; i++) begin
            last_d = bus.m_data;
            last_t = bus.m_tag;
            drive(SSF_EN_IDLE, '0, 1'b1, 1'b0);
            tick("pp.drain");
        end
        check("pp.last_data", 64'(last_d), 64'd9);
        check("pp.last_tag",  64'(last_t), 64'd4);

        // Clear wins over a same-cycle push while the FIFO holds two entries.
        for (int i = 0; i < 5; i++) begin
            drive(SSF_EN_VALID, DW'(20 + i), 1'b0, 1'b0);
            tick("clr.fill");
        end
        for (int i = 0; i < 2; i++) begin
            drive(SSF_EN_IDLE, '0, 1'b1, 1'b0);
            tick("clr.pop");
        end
        check("clr.pre_level", 64'(level), 64'd2);
        check("clr.pre_ovf",   64'(ovf),   64'd1);
        drive(SSF_EN_VALID, 32'd77, 1'b1, 1'b1);
        tick("clr.clear");
        check("clr.level",   64'(level),       64'd0);
        check("clr.m_valid", 64'(bus.m_valid), 64'd0);
        check("clr.ovf",     64'(ovf),         64'd0);
        check("clr.ovf_cnt", 64'(ovf_cnt),     64'd0);
        drive(SSF_EN_VALID, 32'd55, 1'b0, 1'b0);
        tick("clr.next");
        check("clr.next_tag",  64'(bus.m_tag),  64'd0);
        check("clr.next_data", 64'(bus.m_data), 64'd55);

        // Tag wrap: 17 pushes with continuous draining.
        drive(SSF_EN_IDLE, '0, 1'b0, 1'b1);
        tick("wrap.clear");
        for (int i = 0; i < 17; i++) begin
            drive(SSF_EN_VALID, DW'(1000 + i), 1'b1, 1'b0);
            tick("wrap.push");
            check($sformatf("wrap%0d.tag", i),   64'(bus.m_tag),  64'(i % 16));
            check($sformatf("wrap%0d.level", i), 64'(level),      64'd1);
        end
        drive(SSF_EN_IDLE, '0, 1'b1, 1'b0);
        tick("wrap.drain");

        // Drop counter saturation.
        for (int i = 0; i < 24; i++) begin
            drive(SSF_EN_VALID, DW'(i), 1'b0, 1'b0);
            tick("sat.push");
        end
        check("sat.cnt", 64'(ovf_cnt), 64'd15);

        // Reset in the middle of a drain.
        drive(SSF_EN_IDLE, '0, 1'b1, 1'b0);
        tick("rst.drain");
        check("rst.pre_level", 64'(level), 64'd3);
        #2 rst = 1'b1;
        #1;
        check("rst.async_valid", 64'(bus.m_valid), 64'd0);
        check("rst.async_level", 64'(level),       64'd0);
        check("rst.async_cnt",   64'(ovf_cnt),     64'd0);
        model_reset();
        #2 rst = 1'b0;
        drive(SSF_EN_VALID, 32'd8, 1'b0, 1'b0);
        tick("rst.after");
        check("rst.after_tag", 64'(bus.m_tag), 64'd0);

        // Random traffic with alternating drain pressure.
        for (int i = 0; i < 600; i++) begin
            int r;
            logic [1:0] en;
            r  = int'($urandom_range(0, 99));
            en = (r < 70) ? 2'd1 : (r < 88) ? 2'd0 : (r < 94) ? 2'd2 : 2'd3;
            drive(en, $urandom,
                  ((i / 50) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 63) == 0));
            tick("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
